// File: rtl/fxp_add_ctrl_pkg.sv
// Shared types and constants for the fixed-point adder controller.
// The datapath saturates to SAT_MAX/SAT_MIN; sat_add is its reference behaviour.
package fxp_add_ctrl_pkg;

  localparam int DW = 16;
  localparam logic signed [DW-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DW-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_pair_t;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) return s[DW] ? SAT_MIN : SAT_MAX;
    return s[DW-1:0];
  endfunction

endpackage

// File: rtl/fxp_sync_fifo.sv
// Single-clock FIFO, head visible combinationally on dout; power-of-2 depth.
// Push is accepted when not full or when a pop happens on the same edge.
module fxp_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr;
  logic             rd;

  assign rd   = pop && (count != '0);
  assign wr   = push && ((count != FULL) || rd);
  assign dout = mem[rd_ptr];

  // Storage is cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fxp_add_ctrl.sv
// Operand/result buffering and credit-based issue control around a 1-cycle saturating adder.
// Issue is blocked unless the result FIFO has room for every outstanding sum.
module fxp_add_ctrl
  import fxp_add_ctrl_pkg::*;
#(
  parameter int OP_DEPTH  = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          dp_en_out,
  output logic [DW-1:0] dp_a_out,
  output logic [DW-1:0] dp_b_out,
  input  logic [DW-1:0] dp_c_in,
  input  logic          dp_c_valid_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          busy
);

  localparam int OAW = $clog2(OP_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);

  op_pair_t        op_head;
  logic [2*DW-1:0] op_head_raw;
  logic [OAW:0]    op_count;
  logic [RAW:0]    res_count;
  logic            op_push;
  logic            op_empty;
  logic            credit_ok;
  logic            issue;
  logic            inflight;
  logic            res_push;
  logic            res_pop;
  logic [DW-1:0]   last_a;
  logic [DW-1:0]   last_b;
  state_t          state;
  state_t          state_nxt;

  assign in_ready  = op_count < (OAW+1)'(OP_DEPTH);
  assign op_push   = in_valid && in_ready;
  assign op_empty  = (op_count == '0);
  assign op_head   = op_pair_t'(op_head_raw);

  // The sum in flight already owns a result slot, so it counts against the credit.
  assign credit_ok = ({1'b0, res_count} + (RAW+2)'(inflight)) < (RAW+2)'(RES_DEPTH);
  assign issue     = !op_empty && credit_ok;

  assign dp_en_out = issue;
  assign dp_a_out  = issue ? op_head.a : last_a;
  assign dp_b_out  = issue ? op_head.b : last_b;

  assign res_push  = dp_c_valid_in && inflight;
  assign res_valid = (res_count != '0);
  assign res_pop   = res_valid && res_ready;
  assign busy      = (state != ST_IDLE);

  fxp_sync_fifo #(.WIDTH(2*DW), .DEPTH(OP_DEPTH)) u_op_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (op_push),
    .din   ({in_a, in_b}),
    .pop   (issue),
    .dout  (op_head_raw),
    .count (op_count)
  );

  fxp_sync_fifo #(.WIDTH(DW), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (res_push),
    .din   (dp_c_in),
    .pop   (res_pop),
    .dout  (res_data),
    .count (res_count)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      inflight <= 1'b0;
      last_a   <= '0;
      last_b   <= '0;
      state    <= ST_IDLE;
    end else begin
      inflight <= issue;
      if (issue) begin
        last_a <= op_head.a;
        last_b <= op_head.b;
      end
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (op_push) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!op_empty && !credit_ok)
          state_nxt = ST_STALL;
        else if (op_empty && !res_valid && !inflight && !op_push)
          state_nxt = ST_IDLE;
      end
      ST_STALL: begin
        if (res_pop) state_nxt = ST_ACTIVE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fxp_add_ctrl.sv
// Bench for fxp_add_ctrl: the bench plays the 1-cycle saturating adder and checks every cycle
// against a queue-level model, plus an end-to-end scoreboard in acceptance order.
module tb_fxp_add_ctrl;

  localparam int OPD = 4;
  localparam int RSD = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        dp_en_out;
  logic [15:0] dp_a_out;
  logic [15:0] dp_b_out;
  logic [15:0] dp_c_in = '0;
  logic        dp_c_valid_in = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        busy;

  always #5 CLK = ~CLK;

  fxp_add_ctrl #(.OP_DEPTH(OPD), .RES_DEPTH(RSD)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .dp_en_out     (dp_en_out),
    .dp_a_out      (dp_a_out),
    .dp_b_out      (dp_b_out),
    .dp_c_in       (dp_c_in),
    .dp_c_valid_in (dp_c_valid_in),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .busy          (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h7000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Behavioural model state
  logic [31:0] op_q[$];
  logic [15:0] res_q[$];
  logic [15:0] sb_q[$];
  bit          m_infl = 0;
  bit          m_busy = 0;
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;
  int          cyc = 0;
  int          n_issue = 0;
  int          issue_cyc[$];
  int          pop_cyc[$];
  bit          pend = 0;
  logic [15:0] pend_sum = '0;
  bit          spur_en = 0;

  always @(negedge CLK) begin : cmp
    logic        e_rdy, e_en, e_rv;
    logic [15:0] e_a, e_b;
    bit          acc, pop_r, push_r, busy_n;
    cyc++;
    if (!RST) begin
      op_q.delete(); res_q.delete(); sb_q.delete();
      m_infl = 0; m_busy = 0; last_a = '0; last_b = '0; pend = 0;
      chk("rst_res_data", res_data, 16'h0000);
    end
    e_rdy = (op_q.size() < OPD);
    e_en  = (op_q.size() > 0) && ((res_q.size() + int'(m_infl)) < RSD);
    e_a   = e_en ? op_q[0][31:16] : last_a;
    e_b   = e_en ? op_q[0][15:0]  : last_b;
    e_rv  = (res_q.size() > 0);
    chk("in_ready",  in_ready,  e_rdy);
    chk("dp_en_out", dp_en_out, e_en);
    chk("dp_a_out",  dp_a_out,  e_a);
    chk("dp_b_out",  dp_b_out,  e_b);
    chk("res_valid", res_valid, e_rv);
    chk("busy",      busy,      m_busy);
    if (e_rv) chk("res_data", res_data, res_q[0]);
    if (RST) begin
      acc    = in_valid && e_rdy;
      pop_r  = res_ready && e_rv;
      push_r = dp_c_valid_in && m_infl;
      busy_n = acc || (op_q.size() > 0) || (res_q.size() > 0) || m_infl;
      if (pop_r) begin
        pop_cyc.push_back(cyc);
        if (sb_q.size() == 0) chk("e2e_extra_result", sb_q.size(), 1);
        else begin
          chk("e2e_order", res_data, sb_q[0]);
          void'(sb_q.pop_front());
        end
        void'(res_q.pop_front());
      end
      if (push_r) res_q.push_back(dp_c_in);
      if (e_en) begin
        last_a = e_a; last_b = e_b;
        void'(op_q.pop_front());
        pend = 1; pend_sum = sat16(dp_a_out, dp_b_out);
        n_issue++; issue_cyc.push_back(cyc);
      end else begin
        pend = 0;
      end
      if (acc) begin
        op_q.push_back({in_a, in_b});
        sb_q.push_back(sat16(in_a, in_b));
      end
      m_infl = e_en;
      m_busy = busy_n;
    end
  end

  // Adder datapath stand-in: sum one cycle after the strobe, plus optional stray strobes.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (pend && RST) begin
        dp_c_valid_in = 1'b1; dp_c_in = pend_sum;
      end else if (spur_en && ($urandom_range(0, 2) == 0)) begin
        dp_c_valid_in = 1'b1; dp_c_in = 16'($urandom);
      end else begin
        dp_c_valid_in = 1'b0; dp_c_in = 16'($urandom);
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    logic r;
    int   t;
    t = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (1) begin
      @(negedge CLK); r = in_ready;
      @(posedge CLK); #1;
      if (r) break;
      t++;
      if (t > 200) begin chk("push_timeout", t, 0); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (t < 200) begin
      @(negedge CLK);
      if (!busy && !res_valid) break;
      t++;
      @(posedge CLK); #1;
    end
    chk(nm, busy, 0);
    tick();
  endtask

  task automatic run_single(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    int  e0, lat;
    bit  found;
    res_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    e0 = n_issue; lat = 0; found = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge CLK);
      if (res_valid) begin
        found = 1; lat = i;
        chk("single_data", res_data, exp);
      end
      @(posedge CLK); #1;
    end
    chk("single_latency", lat, 3);
    repeat (3) tick();
    chk("single_issue_count", n_issue - e0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    repeat (3) tick();
    RST = 1'b1;
    repeat (2) tick();

    // Single ops, including both saturation directions
    run_single(16'h0010, 16'h0008, 16'h0018);
    run_single(16'h7000, 16'h7000, 16'h7FFF);
    run_single(16'h8000, 16'hFFFF, 16'h8000);
    wait_idle("single_idle");

    // Backpressure: results stuck, operands fill behind them
    res_ready = 1'b0;
    e0 = n_issue;
    for (int i = 0; i < 8; i++) push_pair(rnd16(), rnd16());
    repeat (4) tick();
    @(negedge CLK);
    chk("bp_issue_count", n_issue - e0, RSD);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_busy", busy, 1);
    tick();
    res_ready = 1'b1;
    wait_idle("bp_drain");

    // Streaming at full throughput
    issue_cyc.delete(); pop_cyc.delete();
    for (int i = 0; i < 16; i++) push_pair(rnd16(), rnd16());
    wait_idle("stream_drain");
    chk("stream_issue_count", issue_cyc.size(), 16);
    chk("stream_pop_count", pop_cyc.size(), 16);
    if (issue_cyc.size() >= 16) chk("stream_issue_span", issue_cyc[15] - issue_cyc[0], 15);
    if (pop_cyc.size() >= 16)   chk("stream_pop_span", pop_cyc[15] - pop_cyc[0], 15);

    // Reset with operands and results buffered
    res_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_pair(rnd16(), rnd16());
    repeat (4) tick();
    @(negedge CLK);
    chk("pre_reset_res_valid", res_valid, 1);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dp_en", dp_en_out, 0);
    chk("rst_dp_a", dp_a_out, 0);
    chk("rst_dp_b", dp_b_out, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    tick();
    RST = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); chk("post_reset_no_result", res_valid, 0);
      tick();
    end

    // Stray datapath strobes while idle
    spur_en = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk("spurious_res_valid", res_valid, 0);
      chk("spurious_busy", busy, 0);
      tick();
    end

    // Random traffic with stray strobes still enabled
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = rnd16();
      in_b      = rnd16();
      res_ready = ($urandom_range(0, 3) != 0) || (i % 50 > 40);
      tick();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle("random_drain");
    chk("random_scoreboard_empty", sb_q.size(), 0);
    spur_en = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
